// File: rtl/fire_control_if.sv
// rtl/fire_control_if.sv - keyboard/rocket-bank side signals of the fire controller
interface fire_control_if;
    logic [7:0]  keycode;
    logic        game_active;
    logic [14:0] EnableRock;
    logic        shoot;
    logic        rocket_ready;
    logic [7:0]  fire_count;

    modport master (
        output keycode, game_active, EnableRock,
        input  shoot, rocket_ready, fire_count
    );

    modport slave (
        input  keycode, game_active, EnableRock,
        output shoot, rocket_ready, fire_count
    );
endinterface

// File: rtl/fire_control.sv
// rtl/fire_control.sv - keycode to one-frame shoot pulse with cooldown, auto-repeat and live-rocket cap
module fire_control #(
    parameter logic [7:0] FIRE_KEY    = 8'h2C,
    parameter int         COOLDOWN    = 8,
    parameter int         AUTO_DELAY  = 20,
    parameter int         AUTO_PERIOD = 12,
    parameter int         MAX_LIVE    = 2
) (
    input  logic            frame_clk,
    input  logic            Reset,
    fire_control_if.slave   fc
);
    typedef enum logic [1:0] {IDLE, FIRE, COOL, HOLD} state_t;

    localparam logic [7:0] COOL_LD   = 8'(COOLDOWN - 1);
    localparam logic [7:0] DELAY_LD  = 8'(AUTO_DELAY - 1);
    localparam logic [7:0] PERIOD_LD = 8'(AUTO_PERIOD - 1);
    localparam logic [3:0] LIVE_CAP  = 4'(MAX_LIVE);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       first, first_n;
    logic [7:0] count, count_n;
    logic [3:0] live;
    logic       pressed;
    logic       ready;

    always_comb begin
        live = 4'd0;
        for (int i = 0; i < 15; i++) begin
            live = live + {3'd0, fc.EnableRock[i]};
        end
    end

    assign pressed = fc.game_active && (fc.keycode == FIRE_KEY);
    assign ready   = (live < LIVE_CAP);

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            first <= 1'b0;
            count <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            first <= first_n;
            count <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        first_n = first;
        count_n = count;
        case (state)
            IDLE: begin
                if (pressed && ready) begin
                    state_n = FIRE;
                    first_n = 1'b1;
                end
            end
            FIRE: begin
                count_n = count + 8'd1;
                cnt_n   = COOL_LD;
                state_n = COOL;
            end
            COOL: begin
                // Releasing the key here must not shorten the cooldown.
                if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else if (pressed) begin
                    state_n = HOLD;
                    cnt_n   = first ? DELAY_LD : PERIOD_LD;
                end else begin
                    state_n = IDLE;
                end
            end
            HOLD: begin
                if (!pressed) begin
                    state_n = IDLE;
                end else if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else if (ready) begin
                    state_n = FIRE;
                    first_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (!fc.game_active) begin
            state_n = IDLE;
        end
    end

    always_comb begin
        fc.shoot        = (state == FIRE);
        fc.rocket_ready = ready;
        fc.fire_count   = count;
    end
endmodule

// File: tb/tb_fire_control.sv
// tb/tb_fire_control.sv - self-checking bench for fire_control
module tb_fire_control;
    localparam logic [7:0] FIRE_KEY    = 8'h2C;
    localparam int         COOLDOWN    = 8;
    localparam int         AUTO_DELAY  = 20;
    localparam int         AUTO_PERIOD = 12;
    localparam int         MAX_LIVE    = 2;

    localparam int M_IDLE = 0;
    localparam int M_FIRE = 1;
    localparam int M_COOL = 2;
    localparam int M_HOLD = 3;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    fire_control_if fc ();

    fire_control #(
        .FIRE_KEY(FIRE_KEY), .COOLDOWN(COOLDOWN), .AUTO_DELAY(AUTO_DELAY),
        .AUTO_PERIOD(AUTO_PERIOD), .MAX_LIVE(MAX_LIVE)
    ) dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .fc(fc)
    );

    always #5 frame_clk = ~frame_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: absolute frame deadlines instead of down-counters.
    int         frame      = 0;
    int         m_mode     = M_IDLE;
    int         m_deadline = 0;
    logic       m_first    = 1'b0;
    logic [7:0] m_count    = 8'd0;

    logic obs_shoot  = 1'b0;
    logic prev_shoot = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (frame %0d)", name, act, exp, frame);
        end
    endtask

    task automatic model_step(input logic r, input logic [7:0] k, input logic g, input logic [14:0] e);
        logic pressed;
        logic ready;
        pressed = g && (k == FIRE_KEY);
        ready   = ($countones(e) < MAX_LIVE);
        if (r) begin
            m_mode  = M_IDLE;
            m_first = 1'b0;
            m_count = 8'd0;
        end else begin
            case (m_mode)
                M_IDLE: if (pressed && ready) begin
                    m_mode  = M_FIRE;
                    m_first = 1'b1;
                end
                M_FIRE: begin
                    m_count = m_count + 8'd1;
                    if (!g) m_mode = M_IDLE;
                    else begin
                        m_mode     = M_COOL;
                        m_deadline = frame + COOLDOWN;
                    end
                end
                M_COOL: begin
                    if (!g) m_mode = M_IDLE;
                    else if (frame == m_deadline) begin
                        if (pressed) begin
                            m_mode     = M_HOLD;
                            m_deadline = frame + (m_first ? AUTO_DELAY : AUTO_PERIOD);
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
                default: begin
                    if (!pressed) m_mode = M_IDLE;
                    else if (frame >= m_deadline && ready) begin
                        m_mode  = M_FIRE;
                        m_first = 1'b0;
                    end
                end
            endcase
        end
    endtask

    task automatic step(input logic r, input logic [7:0] k, input logic g, input logic [14:0] e);
        Reset          = r;
        fc.keycode     = k;
        fc.game_active = g;
        fc.EnableRock  = e;
        @(posedge frame_clk);
        model_step(r, k, g, e);
        #1;
        obs_shoot = fc.shoot;
        check("shoot", 32'(fc.shoot), 32'(m_mode == M_FIRE));
        check("fire_count", 32'(fc.fire_count), 32'(m_count));
        check("rocket_ready", 32'(fc.rocket_ready), 32'($countones(e) < MAX_LIVE));
        check("no_back_to_back", 32'(obs_shoot && prev_shoot), 32'd0);
        prev_shoot = obs_shoot;
        frame++;
    endtask

    typedef struct {
        logic        r;
        logic [7:0]  k;
        logic        g;
        logic [14:0] e;
        logic        x_shoot;
        logic [7:0]  x_count;
        logic        x_ready;
    } vec_t;

    vec_t tbl[12];
    int   pulses[$];
    int   exp_hold[4];
    int   exp_ga[2];

    initial begin
        fc.keycode     = 8'h00;
        fc.game_active = 1'b1;
        fc.EnableRock  = 15'd0;

        tbl[0]  = '{1'b1, 8'h2C, 1'b1, 15'h0000, 1'b0, 8'd0, 1'b1};
        tbl[1]  = '{1'b1, 8'h2C, 1'b1, 15'h0000, 1'b0, 8'd0, 1'b1};
        tbl[2]  = '{1'b1, 8'h2C, 1'b1, 15'h0000, 1'b0, 8'd0, 1'b1};
        tbl[3]  = '{1'b0, 8'h2C, 1'b1, 15'h0000, 1'b1, 8'd0, 1'b1};
        tbl[4]  = '{1'b0, 8'h2C, 1'b1, 15'h0000, 1'b0, 8'd1, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 15'h0003, 1'b0, 8'd1, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 15'h0001, 1'b0, 8'd1, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 15'h7FFF, 1'b0, 8'd1, 1'b0};
        tbl[8]  = '{1'b0, 8'h2C, 1'b1, 15'h0000, 1'b0, 8'd1, 1'b1};
        tbl[9]  = '{1'b0, 8'h2C, 1'b1, 15'h0000, 1'b0, 8'd1, 1'b1};
        tbl[10] = '{1'b0, 8'h2C, 1'b1, 15'h0000, 1'b0, 8'd1, 1'b1};
        tbl[11] = '{1'b0, 8'h2C, 1'b1, 15'h0000, 1'b0, 8'd1, 1'b1};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].k, tbl[i].g, tbl[i].e);
            check($sformatf("tbl%0d_shoot", i), 32'(fc.shoot), 32'(tbl[i].x_shoot));
            check($sformatf("tbl%0d_count", i), 32'(fc.fire_count), 32'(tbl[i].x_count));
            check($sformatf("tbl%0d_ready", i), 32'(fc.rocket_ready), 32'(tbl[i].x_ready));
        end

        // Held key, free slots: auto-repeat cadence.
        exp_hold = '{0, 29, 50, 71};
        step(1'b1, 8'h00, 1'b1, 15'd0);
        pulses.delete();
        for (int i = 0; i < 80; i++) begin
            step(1'b0, FIRE_KEY, 1'b1, 15'd0);
            if (obs_shoot) pulses.push_back(i);
        end
        check("hold_npulses", 32'(pulses.size()), 32'd4);
        for (int j = 0; j < 4 && j < pulses.size(); j++)
            check($sformatf("hold_pulse%0d", j), 32'(pulses[j]), 32'(exp_hold[j]));
        check("hold_count", 32'(fc.fire_count), 32'd4);

        // Bank full: held key waits until a slot frees.
        step(1'b1, 8'h00, 1'b1, 15'd0);
        pulses.delete();
        for (int i = 0; i <= 40; i++) begin
            step(1'b0, FIRE_KEY, 1'b1, 15'h0003);
            if (obs_shoot) pulses.push_back(i);
        end
        check("full_no_pulse", 32'(pulses.size()), 32'd0);
        step(1'b0, FIRE_KEY, 1'b1, 15'h0001);
        check("slot_free_pulse", 32'(fc.shoot), 32'd1);

        // game_active drop during cooldown, then re-raise.
        exp_ga = '{0, 10};
        step(1'b1, 8'h00, 1'b1, 15'd0);
        pulses.delete();
        for (int i = 0; i <= 11; i++) begin
            step(1'b0, FIRE_KEY, (i < 4 || i > 9), 15'd0);
            if (obs_shoot) pulses.push_back(i);
        end
        check("ga_npulses", 32'(pulses.size()), 32'd2);
        for (int j = 0; j < 2 && j < pulses.size(); j++)
            check($sformatf("ga_pulse%0d", j), 32'(pulses[j]), 32'(exp_ga[j]));
        check("ga_count", 32'(fc.fire_count), 32'd2);

        // 256 taps: counter wraps.
        step(1'b1, 8'h00, 1'b1, 15'd0);
        pulses.delete();
        for (int t = 0; t < 256; t++) begin
            step(1'b0, FIRE_KEY, 1'b1, 15'd0);
            if (obs_shoot) pulses.push_back(t);
            for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 15'd0);
        end
        check("tap_npulses", 32'(pulses.size()), 32'd256);
        check("tap_wrap", 32'(fc.fire_count), 32'd0);

        // Randomized run against the model.
        begin
            logic [14:0] en;
            logic [7:0]  key;
            int          sel;
            en = 15'd0;
            for (int i = 0; i < 3000; i++) begin
                sel = int'($urandom_range(0, 9));
                key = (sel < 7) ? FIRE_KEY : (sel < 9) ? 8'h00 : 8'($urandom);
                if ($urandom_range(0, 9) == 0) begin
                    sel = int'($urandom_range(0, 4));
                    en = (sel == 0) ? 15'h0000 : (sel == 1) ? 15'h0100 :
                         (sel == 2) ? 15'h0003 : (sel == 3) ? 15'h4001 : 15'($urandom);
                end
                step($urandom_range(0, 99) == 0, key, $urandom_range(0, 19) != 0, en);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fire_control.md
# fire_control

Frame-rate fire controller that sits directly upstream of the rocket bank. It converts the raw keyboard keycode into the one-frame `shoot` pulse the rocket allocator consumes. Enforces a minimum frame gap between shots, optional auto-repeat while the fire key is held, and a cap on rockets simultaneously in flight, using the bank's per-slot enable vector as feedback.

## Interface
- `FIRE_KEY`, 8'h2C, keycode that means "fire" (space).
- `COOLDOWN`, 8, frames `shoot` stays low after a shot; must be ≥1.
- `AUTO_DELAY`, 20, extra hold frames before the first auto-repeat shot; must be ≥1.
- `AUTO_PERIOD`, 12, extra hold frames between subsequent auto-repeat shots; must be ≥1.
- `MAX_LIVE`, 2, maximum rockets in flight (1..15).
- `frame_clk`  in  1  clock, one rising edge per video frame.
- `Reset`  in  1  synchronous, active-high.
- `keycode`  in  8  current keyboard keycode; 8'h00 = none.
- `game_active`  in  1  high while play is allowed.
- `EnableRock`  in  15  per-slot "rocket alive" vector from the rocket bank.
- `shoot`  out  1  fire request to the rocket allocator.
- `rocket_ready`  out  1  high when live count < `MAX_LIVE`.
- `fire_count`  out  8  shots issued since reset, wraps.

## Operation
- `pressed` = `game_active` && (`keycode` == `FIRE_KEY`).
- `live` = popcount(`EnableRock`), 4 bits. `rocket_ready` = (`live` < `MAX_LIVE`), combinational.
- State register: IDLE, FIRE, COOL, HOLD. Down-counter `cnt`, 8 bits. Flag `first`.
- Outputs are Moore: `shoot` = (state == FIRE).
- State transitions:
  - IDLE: if `pressed` && `rocket_ready`, go to FIRE and set `first`=1. Otherwise stay in IDLE. A held key fires as soon as a slot frees.
  - FIRE: `fire_count`++ (8-bit wrap). Load `cnt` = `COOLDOWN`-1. Go to COOL.
  - COOL: if `cnt` != 0, decrement. If `cnt` == 0:
    - `pressed`: go to HOLD, load `cnt` = (`first` ? `AUTO_DELAY` : `AUTO_PERIOD`) - 1.
    - else: go to IDLE.
  - HOLD: if !`pressed`, go to IDLE.
    - Else if `cnt` != 0, decrement.
    - Else if `rocket_ready`, go to FIRE and clear `first`.
    - Else stay in HOLD with `cnt` = 0.
- `game_active` low forces the next state to IDLE from any state; no FIRE is entered.
- Key release during COOL does not shorten the cooldown. The cooldown always completes before any new shot.
- Reset values:
  - state IDLE, `shoot` 0, `cnt` 0, `first` 0, `fire_count` 0.
  - `rocket_ready` follows `EnableRock`.
- Reset asserted mid-FIRE drops `shoot` the next frame without incrementing `fire_count`. Reset has priority over every transition.

## Timing
- `pressed` sampled at edge k in IDLE gives FIRE from edge k, so `shoot` is high for exactly one frame (k to k+1). The allocator samples it at k+1.
- `shoot` is low for at least `COOLDOWN` frames after every pulse. This guarantees the allocator sees a low frame and re-arms.
- `EnableRock` of the new rocket rises one frame after the pulse, inside COOL, so `live` is current before the next shot decision.
- Held key, defaults, free slots:
  - first shot at edge k;
  - second at k+`COOLDOWN`+`AUTO_DELAY`+1 = k+29;
  - each later shot +`COOLDOWN`+`AUTO_PERIOD`+1 = +21.
- Tap (press ≤ `COOLDOWN` frames): exactly one pulse. Next press accepted from the edge COOL reaches `cnt`==0.

## Test plan
- Reset held 3 frames with `keycode`=8'h2C, `game_active`=1 -> `shoot`=0 and `fire_count`=0 throughout; `shoot` high in the first frame after Reset drops.
- Tap: `keycode`=8'h2C for 2 frames, then 8'h00 -> one `shoot` pulse of width 1; `fire_count`=1; no further pulse within 40 frames.
- Hold 80 frames, `EnableRock`=0 -> pulses at frames 0, 29, 50, 71 relative to the first; `fire_count`=4; every pulse 1 frame wide.
- `EnableRock`=15'h0003 with key held -> `rocket_ready`=0, no pulse. Drop to 15'h0001 at frame 40 -> pulse in frame 41.
- `game_active` dropped 3 frames into COOL with key held -> no pulse while low. Re-raised -> pulse from IDLE one frame later.
- 256 taps spaced 12 frames apart -> `fire_count` wraps to 8'h00; `shoot` never high two consecutive frames.
